instruction_fetch: RTL and testbench

Fetch stage of the 64-bit pipelined CPU: owns the program counter, issues instruction-memory reads, buffers fetched words in a small FIFO and hands {PC, instruction} pairs to decode. It is the consuming end of the branch-resolution path, taking the taken-branch strobe and branch target from the memory-access stage and redirecting fetch, discarding wrong-path work.

---
 rtl/instruction_fetch_pkg.sv | 18 +
 rtl/instruction_fetch_fifo.sv | 55 +++++
 rtl/instruction_fetch.sv | 117 +++++++++++
 tb/tb_instruction_fetch.sv | 297 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/instruction_fetch_pkg.sv
// rtl/instruction_fetch_pkg.sv - shared fetch-stage widths, state encoding and pc helpers
package instruction_fetch_pkg;
  localparam int ADDR_W  = 64;
  localparam int INSTR_W = 32;
  localparam int ENTRY_W = ADDR_W + INSTR_W;
  localparam logic [ADDR_W-1:0] PC_INCR = 64'd4;

  typedef enum logic [1:0] {
    ST_REQ  = 2'd0,
    ST_WAIT = 2'd1,
    ST_DROP = 2'd2,
    ST_HOLD = 2'd3
  } fetch_state_e;

  function automatic logic [ADDR_W-1:0] word_align(input logic [ADDR_W-1:0] addr);
    return {addr[ADDR_W-1:2], 2'b00};
  endfunction
endpackage

// File: rtl/instruction_fetch_fifo.sv
// rtl/instruction_fetch_fifo.sv - synchronous {pc, instr} buffer with push/pop/flush and count
module instruction_fetch_fifo
  import instruction_fetch_pkg::*;
#(
  parameter int DEPTH = 2,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = PTR_W + 1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               i_push,
  input  logic [ENTRY_W-1:0] i_data,
  input  logic               i_pop,
  input  logic               i_flush,
  output logic [ENTRY_W-1:0] o_head,
  output logic [CNT_W-1:0]   o_count
);
  logic [ENTRY_W-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0]   r_wr_ptr;
  logic [PTR_W-1:0]   r_rd_ptr;
  logic [CNT_W-1:0]   r_count;
  logic               w_pop;
  logic               w_push;

  // A push into a full buffer is only accepted when the head leaves in the same cycle.
  assign w_pop  = i_pop && (r_count != '0);
  assign w_push = i_push && ((r_count != CNT_W'(DEPTH)) || w_pop);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= '0;
      end
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (i_flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) begin
        r_mem[r_wr_ptr] <= i_data;
        r_wr_ptr        <= r_wr_ptr + PTR_W'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      end
      r_count <= r_count + CNT_W'(w_push) - CNT_W'(w_pop);
    end
  end

  assign o_head  = r_mem[r_rd_ptr];
  assign o_count = r_count;
endmodule

// File: rtl/instruction_fetch.sv
// rtl/instruction_fetch.sv - fetch stage: pc, single-outstanding imem reads, redirect and flush
module instruction_fetch
  import instruction_fetch_pkg::*;
#(
  parameter logic [63:0] RESET_PC   = 64'h0,
  parameter int          FIFO_DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        PCSrc,
  input  logic [63:0] BranchAddress,
  output logic        imem_req,
  output logic [63:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [63:0] out_pc,
  output logic [31:0] out_instr,
  output logic        fetch_misalign
);
  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

  fetch_state_e       r_state;
  fetch_state_e       w_next_state;
  logic [ADDR_W-1:0]  r_pc;
  logic               r_started;
  logic               r_misalign;
  logic               w_granted;
  logic               w_push;
  logic               w_pop;
  logic               w_space_after;
  logic [CNT_W-1:0]   w_count;
  logic [CNT_W-1:0]   w_count_after;
  logic [ENTRY_W-1:0] w_head;

  // r_started keeps the request low until the first edge after reset release.
  assign imem_req       = r_started && (r_state == ST_REQ);
  assign imem_addr      = r_pc;
  assign w_granted      = imem_req && imem_gnt;
  assign out_valid      = (w_count != '0);
  assign w_pop          = out_valid && out_ready;
  assign w_push         = (r_state == ST_WAIT) && imem_rvalid && !PCSrc;
  assign w_count_after  = w_count + CNT_W'(w_push) - CNT_W'(w_pop);
  assign w_space_after  = (w_count_after < CNT_W'(FIFO_DEPTH));
  assign out_pc         = w_head[ENTRY_W-1 -: ADDR_W];
  assign out_instr      = w_head[INSTR_W-1:0];
  assign fetch_misalign = r_misalign;

  instruction_fetch_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_push  (w_push),
    .i_data  ({r_pc, imem_rdata}),
    .i_pop   (w_pop),
    .i_flush (PCSrc),
    .o_head  (w_head),
    .o_count (w_count)
  );

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      ST_REQ: begin
        if (w_granted) begin
          w_next_state = PCSrc ? ST_DROP : ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (imem_rvalid) begin
          w_next_state = (PCSrc || w_space_after) ? ST_REQ : ST_HOLD;
        end else if (PCSrc) begin
          w_next_state = ST_DROP;
        end
      end
      ST_DROP: begin
        // The wrong-path response retires the outstanding read even if another redirect lands now.
        if (imem_rvalid) begin
          w_next_state = ST_REQ;
        end
      end
      ST_HOLD: begin
        if (PCSrc || w_pop) begin
          w_next_state = ST_REQ;
        end
      end
      default: w_next_state = ST_REQ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_REQ;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pc       <= RESET_PC;
      r_started  <= 1'b0;
      r_misalign <= 1'b0;
    end else begin
      r_started  <= 1'b1;
      r_misalign <= PCSrc && (BranchAddress[1:0] != 2'b00);
      if (PCSrc) begin
        r_pc <= word_align(BranchAddress);
      end else if (w_push) begin
        r_pc <= r_pc + PC_INCR;
      end
    end
  end
endmodule

// File: tb/tb_instruction_fetch.sv
// tb/tb_instruction_fetch.sv - self-checking bench for instruction_fetch
module tb_instruction_fetch;
  localparam logic [63:0] RST_PC = 64'h400;
  localparam int M_ANY = 0, M_REQ_NOGNT = 1, M_RVALID = 2, M_GNT = 3, M_WAIT = 4, M_HOLD = 5;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        PCSrc;
  logic [63:0] BranchAddress;
  logic        imem_req;
  logic [63:0] imem_addr;
  logic        imem_gnt;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        out_valid;
  logic        out_ready;
  logic [63:0] out_pc;
  logic [31:0] out_instr;
  logic        fetch_misalign;

  instruction_fetch #(
    .RESET_PC   (RST_PC),
    .FIFO_DEPTH (2)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .PCSrc          (PCSrc),
    .BranchAddress  (BranchAddress),
    .imem_req       (imem_req),
    .imem_addr      (imem_addr),
    .imem_gnt       (imem_gnt),
    .imem_rvalid    (imem_rvalid),
    .imem_rdata     (imem_rdata),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_pc         (out_pc),
    .out_instr      (out_instr),
    .fetch_misalign (fetch_misalign)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          mode;
    logic [63:0] target;
    int          lat;
    bit          hold;
    logic [63:0] exp_addr;
    bit          exp_mis;
    bit          exp_req_next;
  } redir_vec_t;

  redir_vec_t vecs[7];

  int errors = 0;
  int checks = 0;
  int cycle = 0;

  int ready_mode, ready_pct, gnt_pct, lat_min, lat_max;
  bit          pend_valid, pend_stale;
  int          pend_cnt;
  logic [63:0] pend_addr;
  logic [63:0] exp_fetch_pc, exp_pop_pc;
  bit          exp_mis_now, prev_redir, inject_stale;
  bit          redir_arm, redir_fired;
  int          redir_mode;
  logic [63:0] redir_target;
  logic [63:0] gnt_q[$];
  int          pop_cycles[$];
  int          gnt_total = 0;
  logic [63:0] last_gnt_addr;

  function automatic logic [31:0] instr_of(input logic [63:0] pc);
    return pc[31:0] ^ pc[63:32] ^ 32'h1357_9BDF;
  endfunction

  task automatic check64(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cycle);
    end
  endtask

  task automatic timeout(input string name);
    checks++;
    errors++;
    $display("FAIL %s: bound expired at cycle %0d", name, cycle);
  endtask

  // One cycle: check what the last edge produced, then drive this cycle's inputs from the model.
  task automatic tick();
    bit deliver, grant, fire;
    check64("misalign", fetch_misalign, exp_mis_now);
    if (prev_redir) check64("flush_valid", out_valid, 0);
    if (pend_valid) check64("one_outstanding", imem_req, 0);

    case (ready_mode)
      1:       out_ready = 1'b1;
      2:       out_ready = 1'b0;
      default: out_ready = ($urandom_range(99) < ready_pct);
    endcase
    if (out_valid && out_ready) begin
      check64("pop_pc", out_pc, exp_pop_pc);
      check64("pop_instr", out_instr, instr_of(exp_pop_pc));
      exp_pop_pc += 64'd4;
      pop_cycles.push_back(cycle);
    end

    deliver = 1'b0;
    if (pend_valid) begin
      if (pend_cnt == 0) deliver = 1'b1;
      else pend_cnt--;
    end
    imem_rvalid = deliver || inject_stale;
    imem_rdata  = deliver ? instr_of(pend_addr) : (inject_stale ? 32'hBAD0_BAD0 : $urandom());
    inject_stale = 1'b0;

    grant = imem_req && ($urandom_range(99) < gnt_pct) && !(redir_arm && redir_mode == M_REQ_NOGNT);
    imem_gnt = grant;
    if (grant) begin
      check64("gnt_addr", imem_addr, exp_fetch_pc);
      gnt_q.push_back(imem_addr);
      last_gnt_addr = imem_addr;
      gnt_total++;
    end

    fire = 1'b0;
    if (redir_arm) begin
      case (redir_mode)
        M_REQ_NOGNT: fire = imem_req;
        M_RVALID:    fire = deliver;
        M_GNT:       fire = grant;
        M_WAIT:      fire = pend_valid && !deliver;
        M_HOLD:      fire = !imem_req && !pend_valid && out_valid;
        default:     fire = 1'b1;
      endcase
    end

    if (deliver) begin
      pend_valid = 1'b0;
      if (!pend_stale && !fire) exp_fetch_pc += 64'd4;
    end
    if (grant) begin
      pend_valid = 1'b1;
      pend_cnt   = $urandom_range(lat_max, lat_min) - 1;
      pend_addr  = imem_addr;
      pend_stale = 1'b0;
    end
    if (fire) begin
      if (pend_valid) pend_stale = 1'b1;
      exp_fetch_pc = {redir_target[63:2], 2'b00};
      exp_pop_pc   = {redir_target[63:2], 2'b00};
      redir_arm    = 1'b0;
      redir_fired  = 1'b1;
    end
    PCSrc         = fire;
    BranchAddress = fire ? redir_target : {$urandom(), $urandom()};
    exp_mis_now   = fire && (redir_target[1:0] != 2'b00);
    prev_redir    = fire;
    @(negedge clk);
    cycle++;
  endtask

  task automatic do_reset(input bit late_rvalid);
    rst_n       = 1'b0;
    PCSrc       = 1'b0;
    imem_gnt    = 1'b0;
    out_ready   = 1'b0;
    imem_rvalid = late_rvalid;
    imem_rdata  = 32'hBAD0_BAD0;
    #1;
    check64("rst_req", imem_req, 0);
    check64("rst_addr", imem_addr, RST_PC);
    check64("rst_valid", out_valid, 0);
    check64("rst_out_pc", out_pc, 0);
    check64("rst_out_instr", out_instr, 0);
    check64("rst_misalign", fetch_misalign, 0);
    @(negedge clk);
    @(negedge clk);
    rst_n        = 1'b1;
    pend_valid   = 1'b0;
    exp_fetch_pc = RST_PC;
    exp_pop_pc   = RST_PC;
    exp_mis_now  = 1'b0;
    prev_redir   = 1'b0;
    redir_arm    = 1'b0;
    inject_stale = late_rvalid;
    gnt_q.delete();
    pop_cycles.delete();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n, g0, p0;
    vecs[0] = '{M_REQ_NOGNT, 64'h2000, 1, 1'b0, 64'h2000, 1'b0, 1'b1};
    vecs[1] = '{M_RVALID,    64'h3000, 1, 1'b0, 64'h3000, 1'b0, 1'b1};
    vecs[2] = '{M_GNT,       64'h4000, 2, 1'b0, 64'h4000, 1'b0, 1'b0};
    vecs[3] = '{M_WAIT,      64'h1000, 3, 1'b0, 64'h1000, 1'b0, 1'b0};
    vecs[4] = '{M_WAIT,      64'h1002, 2, 1'b0, 64'h1000, 1'b1, 1'b0};
    vecs[5] = '{M_HOLD,      64'h5003, 1, 1'b1, 64'h5000, 1'b1, 1'b1};
    vecs[6] = '{M_RVALID,    64'hFFFF_FFFF_FFFF_FFF8, 1, 1'b0, 64'hFFFF_FFFF_FFFF_FFF8, 1'b0, 1'b1};

    rst_n = 1'b0; PCSrc = 1'b0; BranchAddress = '0; imem_gnt = 1'b0;
    imem_rvalid = 1'b0; imem_rdata = '0; out_ready = 1'b0;
    ready_mode = 1; ready_pct = 100; gnt_pct = 100; lat_min = 1; lat_max = 1;
    pend_valid = 1'b0; pend_stale = 1'b0; pend_cnt = 0; pend_addr = '0;
    redir_fired = 1'b0; redir_mode = M_ANY; redir_target = '0; last_gnt_addr = '0;
    @(negedge clk);

    // Reset, then streaming with a 1-cycle memory
    do_reset(1'b0);
    check64("req_pre_edge", imem_req, 0);
    tick();
    check64("req_first", imem_req, 1);
    check64("addr_first", imem_addr, RST_PC);
    repeat (14) tick();
    if (gnt_q.size() < 3 || pop_cycles.size() < 4) timeout("stream_progress");
    else begin
      for (int i = 0; i < 3; i++) check64("stream_gnt", gnt_q[i], RST_PC + 64'(4 * i));
      for (int i = 0; i < 3; i++) check64("cadence", pop_cycles[i+1] - pop_cycles[i], 2);
    end

    // Decode stall: buffer fills, request stops, restarts one cycle after the first pop
    ready_mode = 2;
    repeat (10) tick();
    check64("hold_req", imem_req, 0);
    check64("hold_valid", out_valid, 1);
    p0 = pop_cycles.size();
    ready_mode = 1;
    tick();
    check64("resume_req", imem_req, 1);
    tick();
    check64("drain_empty", out_valid, 0);
    check64("buffered_entries", pop_cycles.size() - p0, 2);
    repeat (4) tick();

    // Redirect scenarios
    foreach (vecs[k]) begin
      lat_min = vecs[k].lat; lat_max = vecs[k].lat; gnt_pct = 100;
      ready_mode = vecs[k].hold ? 2 : 1;
      redir_target = vecs[k].target; redir_mode = vecs[k].mode;
      redir_arm = 1'b1; redir_fired = 1'b0;
      n = 0;
      while (!redir_fired && n < 60) begin tick(); n++; end
      if (!redir_fired) begin
        timeout("redir_fire");
        redir_arm = 1'b0;
      end else begin
        check64("vec_req_next", imem_req, vecs[k].exp_req_next);
        if (vecs[k].exp_req_next) check64("vec_addr_next", imem_addr, vecs[k].exp_addr);
        check64("vec_misalign", fetch_misalign, vecs[k].exp_mis);
        check64("vec_valid_next", out_valid, 0);
        ready_mode = 1;
        g0 = gnt_total; n = 0;
        while (gnt_total == g0 && n < 20) begin tick(); n++; end
        if (gnt_total == g0) timeout("vec_first_gnt");
        else check64("vec_first_gnt", last_gnt_addr, vecs[k].exp_addr);
        repeat (8) tick();
      end
    end

    // Reset during an outstanding read; the late response must be ignored
    lat_min = 3; lat_max = 3;
    n = 0;
    while (!pend_valid && n < 20) begin tick(); n++; end
    if (!pend_valid) timeout("reset_wait_gnt");
    tick();
    do_reset(1'b1);
    lat_min = 1; lat_max = 1;
    repeat (10) tick();
    if (gnt_q.size() == 0 || pop_cycles.size() == 0) timeout("post_reset_fetch");
    else check64("post_reset_gnt", gnt_q[0], RST_PC);

    // Randomized traffic against the model
    ready_mode = 0; ready_pct = 60; gnt_pct = 70; lat_min = 1; lat_max = 3;
    p0 = pop_cycles.size();
    for (int i = 0; i < 1500; i++) begin
      if (!redir_arm && $urandom_range(99) < 3) begin
        redir_arm = 1'b1; redir_mode = M_ANY;
        redir_target = {32'h0, $urandom()};
        if ($urandom_range(3) == 0)
          redir_target = 64'hFFFF_FFFF_FFFF_FFF0 | 64'($urandom_range(15));
      end
      tick();
    end
    check64("random_liveness", (pop_cycles.size() - p0) >= 50, 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
